sipo_frame_ctrl: RTL and testbench

SIPO_FRAME_CTRL -- requirements
Module: sipo_frame_ctrl

---
 rtl/sipo_ctrl_pkg.sv | 12 +
 rtl/sipo_shift_stage.sv | 47 ++++
 rtl/sipo_frame_ctrl.sv | 116 +++++++++++
 tb/tb_sipo_frame_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_ctrl_pkg.sv
// Shared definitions for the serial-in/parallel-out frame controller:
// FSM state encoding and the default frame width.
package sipo_ctrl_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_N = 8;

endpackage

// File: rtl/sipo_shift_stage.sv
// N-bit left shift register (MSB-first capture) with synchronous clear that
// takes priority over the shift enable.
module sipo_shift_stage
    import sipo_ctrl_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         shift_en,
    input  logic         din,
    output logic [N-1:0] q
);

    logic [N-1:0] q_q;
    logic [N-1:0] q_d;
    logic [N-1:0] shifted;

    assign shifted[0] = din;

    generate
        for (genvar gi = 1; gi < N; gi++) begin : g_shift
            assign shifted[gi] = q_q[gi-1];
        end
    endgenerate

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (shift_en) begin
            q_d = shifted;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Frame controller: collects N serial bits per frame (MSB first) and offers
// each completed word through a valid/ready output register.
module sipo_frame_ctrl
    import sipo_ctrl_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     bit_en,
    input  logic                     serial_in,
    input  logic                     out_ready,
    output logic [N-1:0]             out_data,
    output logic                     out_valid,
    output logic                     busy,
    output logic [$clog2(N+1)-1:0]   bit_count,
    output logic                     overrun
);

    localparam int CW = $clog2(N+1);

    state_t          state_q, state_d;
    logic [CW-1:0]   bit_count_q, bit_count_d;
    logic [N-1:0]    out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic            overrun_q, overrun_d;

    logic [N-1:0]    sr;
    logic            sr_clr;
    logic            sr_shift;
    logic            last_bit;
    logic [N-1:0]    word;
    logic            unused_sr_msb;

    sipo_shift_stage #(.N(N)) u_shift (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (sr_clr),
        .shift_en (sr_shift),
        .din      (serial_in),
        .q        (sr)
    );

    // The final bit is merged combinationally so the word lands in the
    // output register on the same edge that samples it.
    assign word          = {sr[N-2:0], serial_in};
    assign last_bit      = (bit_count_q == CW'(N-1));
    assign unused_sr_msb = sr[N-1];

    always_comb begin
        state_d     = state_q;
        bit_count_d = bit_count_q;
        sr_clr      = 1'b0;
        sr_shift    = 1'b0;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q & ~out_ready;
        overrun_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d     = SHIFT;
                    bit_count_d = '0;
                    sr_clr      = 1'b1;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d     = IDLE;
                    bit_count_d = '0;
                end else if (bit_en) begin
                    sr_shift = 1'b1;
                    if (last_bit) begin
                        state_d     = IDLE;
                        bit_count_d = '0;
                        // A pending word that is not being taken this edge wins.
                        if (!out_valid_q || out_ready) begin
                            out_data_d  = word;
                            out_valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        bit_count_d = bit_count_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_count_q <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_count_q <= bit_count_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == SHIFT);
    assign bit_count = bit_count_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Bench for sipo_frame_ctrl: directed frame scenarios followed by random
// traffic, all compared against a frame-level reference model.
module tb_sipo_frame_ctrl;

    localparam int N  = 8;
    localparam int CW = $clog2(N+1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic          bit_en;
    logic          serial_in;
    logic          out_ready;
    logic [N-1:0]  out_data;
    logic          out_valid;
    logic          busy;
    logic [CW-1:0] bit_count;
    logic          overrun;

    int errors = 0;
    int checks = 0;

    // Reference model: frame progress and the pending output word.
    bit          m_busy;
    int          m_cnt;
    int unsigned m_word;
    bit          m_valid;
    logic [N-1:0] m_data;
    bit          m_ovr;

    sipo_frame_ctrl #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .bit_en    (bit_en),
        .serial_in (serial_in),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .busy      (busy),
        .bit_count (bit_count),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy  = 0;
        m_cnt   = 0;
        m_word  = 0;
        m_valid = 0;
        m_data  = '0;
        m_ovr   = 0;
    endtask

    task automatic model_step();
        bit nxt_valid;
        nxt_valid = m_valid && !out_ready;
        m_ovr = 0;
        if (!m_busy) begin
            if (start && !abort) begin
                m_busy = 1;
                m_cnt  = 0;
                m_word = 0;
            end
        end else if (abort) begin
            m_busy = 0;
            m_cnt  = 0;
        end else if (bit_en) begin
            m_word = (m_word << 1) | 32'(serial_in);
            m_cnt++;
            if (m_cnt == N) begin
                m_busy = 0;
                m_cnt  = 0;
                if (!m_valid || out_ready) begin
                    m_data    = m_word[N-1:0];
                    nxt_valid = 1;
                end else begin
                    m_ovr = 1;
                end
            end
        end
        m_valid = nxt_valid;
    endtask

    task automatic check_all(input string where);
        chk({where, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        chk({where, ".out_data"},  32'(out_data),  32'(m_data));
        chk({where, ".busy"},      32'(busy),      32'(m_busy));
        chk({where, ".bit_count"}, 32'(bit_count), 32'(m_cnt));
        chk({where, ".overrun"},   32'(overrun),   32'(m_ovr));
    endtask

    // Inputs are driven 1 time unit after a rising edge and checked there.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all("cycle");
    endtask

    task automatic send_frame(input logic [N-1:0] w, input int gap, input bit rdy_last);
        start  = 1;
        bit_en = 0;
        tick();
        start = 0;
        for (int i = N-1; i >= 0; i--) begin
            repeat (gap) begin
                bit_en    = 0;
                serial_in = 1'($urandom);
                tick();
            end
            bit_en    = 1;
            serial_in = w[i];
            if (i == 0 && rdy_last) out_ready = 1;
            tick();
        end
        bit_en = 0;
    endtask

    task automatic reset_pulse();
        #2 rst_n = 0;
        #1;
        model_reset();
        check_all("async_reset");
        #2 rst_n = 1;
    endtask

    initial begin
        rst_n = 0; start = 0; abort = 0; bit_en = 0; serial_in = 0; out_ready = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        #3 rst_n = 1;
        @(posedge clk);
        #1;
        check_all("post_reset");

        // Basic frame, consumer always ready.
        out_ready = 1;
        send_frame(8'hB2, 0, 0);
        chk("basic.data", 32'(out_data), 32'h0000_00B2);
        chk("basic.valid", 32'(out_valid), 32'd1);
        tick();
        chk("basic.valid_drop", 32'(out_valid), 32'd0);

        // Strobe every third cycle.
        send_frame(8'hB2, 2, 0);
        chk("gapped.data", 32'(out_data), 32'h0000_00B2);
        tick();

        // Overrun: B2 held, 5A dropped.
        out_ready = 0;
        send_frame(8'hB2, 0, 0);
        send_frame(8'h5A, 1, 0);
        chk("overrun.pulse", 32'(overrun), 32'd1);
        chk("overrun.data", 32'(out_data), 32'h0000_00B2);
        tick();
        chk("overrun.single", 32'(overrun), 32'd0);
        out_ready = 1;
        tick();
        chk("overrun.drain", 32'(out_valid), 32'd0);

        // Back-to-back: ready only on the completion edge of the second frame.
        out_ready = 0;
        send_frame(8'hB2, 0, 0);
        send_frame(8'h0F, 0, 1);
        chk("b2b.valid", 32'(out_valid), 32'd1);
        chk("b2b.data", 32'(out_data), 32'h0000_000F);
        chk("b2b.no_overrun", 32'(overrun), 32'd0);
        tick();

        // Abort after 3 bits with a word pending.
        out_ready = 0;
        send_frame(8'hE7, 0, 0);
        start = 1; tick(); start = 0;
        for (int i = 0; i < 3; i++) begin
            bit_en = 1; serial_in = 1'($urandom); tick();
        end
        abort = 1; bit_en = 1; tick();
        abort = 0; bit_en = 0;
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.count", 32'(bit_count), 32'd0);
        chk("abort.valid", 32'(out_valid), 32'd1);
        chk("abort.data", 32'(out_data), 32'h0000_00E7);
        out_ready = 1;
        tick();
        send_frame(8'hC3, 0, 0);
        chk("abort.next", 32'(out_data), 32'h0000_00C3);
        tick();

        // Start and abort together in IDLE.
        start = 1; abort = 1; tick();
        start = 0; abort = 0;
        chk("start_abort.busy", 32'(busy), 32'd0);

        // Reset mid-frame after 5 bits.
        start = 1; tick(); start = 0;
        for (int i = 0; i < 5; i++) begin
            bit_en = 1; serial_in = 1'($urandom); tick();
        end
        bit_en = 0;
        reset_pulse();
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.count", 32'(bit_count), 32'd0);
        start = 1; tick(); start = 0;
        chk("rst.first_start", 32'(busy), 32'd1);
        for (int i = 0; i < N; i++) begin
            bit_en = 1; serial_in = 1'(i & 1); tick();
        end
        bit_en = 0;
        chk("rst.new_frame", 32'(out_data), 32'h0000_0055);
        tick();

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            start     = ($urandom_range(0, 99) < 30);
            abort     = ($urandom_range(0, 99) < 4);
            bit_en    = ($urandom_range(0, 99) < 60);
            serial_in = 1'($urandom);
            out_ready = ($urandom_range(0, 99) < 45);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
